balance_pid: RTL and testbench

//  Pitch-balance PID stage, directly downstream of inert_intf: consumes each vld-qualified 16-bit ptch

---
 rtl/segway_pkg.sv | 33 +++
 rtl/ptch_D_queue.sv | 31 +++
 rtl/balance_pid.sv | 98 +++++++++
 tb/tb_balance_pid.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared widths, pipeline payload type and saturation helper for the balance controller.
package segway_pkg;

    localparam int unsigned PTCH_W  = 16;
    localparam int unsigned ERR_W   = 10;
    localparam int unsigned INTEG_W = 18;
    localparam int unsigned DSAT_W  = 7;
    localparam int unsigned DIFF_W  = ERR_W + 1;
    localparam int unsigned TERM_W  = 16;
    localparam int unsigned SUM_W   = TERM_W + 1;

    typedef struct packed {
        logic signed [TERM_W-1:0] p;
        logic signed [TERM_W-1:0] i;
        logic signed [TERM_W-1:0] d;
    } pid_terms_t;

    // Clamp a signed value into the range representable by a signed field of 'width' bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int unsigned width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/ptch_D_queue.sv
// Short history of saturated errors; the oldest entry is the reference for the D difference.
module ptch_D_queue
    import segway_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic             i_clr,
    input  logic [ERR_W-1:0] i_din,
    output logic [ERR_W-1:0] o_oldest
);

    logic [ERR_W-1:0] r_q [DEPTH];

    // Clear wins over shift so a powered-down controller restarts with an empty history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else if (i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else if (i_shift) begin
            r_q[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) r_q[i] <= r_q[i-1];
        end
    end

    assign o_oldest = r_q[DEPTH-1];

endmodule

// File: rtl/balance_pid.sv
// Three-stage pitch PID: saturate error, form P/I/D terms, sum and saturate to the command.
module balance_pid
    import segway_pkg::*;
#(
    parameter int unsigned P_COEFF = 5,
    parameter int unsigned D_COEFF = 9,
    parameter int unsigned D_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic [PTCH_W-1:0] ptch,
    input  logic              pwr_up,
    input  logic              rider_off,
    output logic [TERM_W-1:0] PID_cntrl,
    output logic              PID_vld
);

    localparam logic signed [TERM_W-1:0] P_GAIN = TERM_W'(P_COEFF);
    localparam logic signed [TERM_W-1:0] D_GAIN = TERM_W'(D_COEFF);

    logic                      r_s1_vld;
    logic signed [ERR_W-1:0]   r_err_sat;
    logic                      r_s2_vld;
    pid_terms_t                r_terms;
    logic signed [INTEG_W-1:0] r_integ;

    logic signed [ERR_W-1:0]   w_err_sat;
    logic signed [INTEG_W-1:0] w_err_ext;
    logic signed [INTEG_W-1:0] w_integ_sum;
    logic                      w_integ_ovf;
    logic signed [INTEG_W-1:0] w_integ_nxt;
    logic [ERR_W-1:0]          w_q_oldest;
    logic signed [DIFF_W-1:0]  w_diff;
    logic signed [DSAT_W-1:0]  w_d_sat;
    logic signed [TERM_W-1:0]  w_err16;
    pid_terms_t                w_terms;
    logic signed [SUM_W-1:0]   w_sum;

    assign w_err_sat = ERR_W'(sat_signed(32'($signed(ptch)), ERR_W));

    // Integrator: disable/rider-off clear every cycle; signed overflow freezes it.
    always_comb begin
        w_err_ext   = INTEG_W'(r_err_sat);
        w_integ_sum = r_integ + w_err_ext;
        w_integ_ovf = (r_integ[INTEG_W-1] == w_err_ext[INTEG_W-1]) &&
                      (w_integ_sum[INTEG_W-1] != r_integ[INTEG_W-1]);
        w_integ_nxt = r_integ;
        if (!pwr_up || rider_off) begin
            w_integ_nxt = '0;
        end else if (r_s1_vld && !w_integ_ovf) begin
            w_integ_nxt = w_integ_sum;
        end
    end

    ptch_D_queue #(
        .DEPTH(D_DEPTH)
    ) u_d_queue (
        .clk      (clk),
        .rst      (rst),
        .i_shift  (r_s1_vld),
        .i_clr    (!pwr_up),
        .i_din    (r_err_sat),
        .o_oldest (w_q_oldest)
    );

    always_comb begin
        w_err16   = TERM_W'(r_err_sat);
        w_diff    = DIFF_W'(r_err_sat) - DIFF_W'($signed(w_q_oldest));
        w_d_sat   = DSAT_W'(sat_signed(32'(w_diff), DSAT_W));
        w_terms.p = TERM_W'(w_err16 * P_GAIN);
        w_terms.i = TERM_W'($signed(w_integ_nxt[INTEG_W-1:6]));
        w_terms.d = TERM_W'(TERM_W'(w_d_sat) * D_GAIN);
        w_sum     = SUM_W'($signed(r_terms.p)) + SUM_W'($signed(r_terms.i)) +
                    SUM_W'($signed(r_terms.d));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_err_sat <= '0;
            r_s2_vld  <= 1'b0;
            r_terms   <= '0;
            r_integ   <= '0;
            PID_cntrl <= '0;
            PID_vld   <= 1'b0;
        end else begin
            r_s1_vld <= vld;
            if (vld) r_err_sat <= w_err_sat;
            r_s2_vld <= r_s1_vld;
            r_integ  <= w_integ_nxt;
            if (r_s1_vld) r_terms <= w_terms;
            PID_vld  <= r_s2_vld;
            if (r_s2_vld) PID_cntrl <= TERM_W'(sat_signed(32'(w_sum), TERM_W));
        end
    end

endmodule

// File: tb/tb_balance_pid.sv
// Directed bench for balance_pid with hand-computed PID commands.
module tb_balance_pid;

    logic        clk;
    logic        rst;
    logic        vld;
    logic [15:0] ptch;
    logic        pwr_up;
    logic        rider_off;
    logic [15:0] PID_cntrl;
    logic        PID_vld;

    int n_checks;
    int n_errors;
    int got[$];

    balance_pid dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .ptch      (ptch),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .PID_cntrl (PID_cntrl),
        .PID_vld   (PID_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every command strobed out, in order.
    always @(negedge clk) begin
        if (PID_vld === 1'b1) got.push_back(int'($signed(PID_cntrl)));
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] p);
        vld  = 1'b1;
        ptch = p;
        @(posedge clk);
        #1;
        vld  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        got.delete();
    endtask

    int neg_cnt;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        vld       = 1'b0;
        ptch      = '0;
        pwr_up    = 1'b1;
        rider_off = 1'b0;

        // Reset state and quiet idle
        idle(3);
        chk("rst_cntrl", int'($signed(PID_cntrl)), 0);
        chk("rst_vld", int'(PID_vld), 0);
        rst = 1'b0;
        got.delete();
        idle(20);
        chk("idle_no_vld", got.size(), 0);
        chk("idle_cntrl", int'($signed(PID_cntrl)), 0);

        // Single sample, latency 2
        do_reset();
        send(16'h0100);
        chk("s2_vld_n0", int'(PID_vld), 0);
        idle(1);
        chk("s2_vld_n1", int'(PID_vld), 0);
        idle(1);
        chk("s2_vld_n2", int'(PID_vld), 1);
        chk("s2_cntrl", int'($signed(PID_cntrl)), 1851);
        idle(1);
        chk("s2_vld_n3", int'(PID_vld), 0);
        chk("s2_hold", int'($signed(PID_cntrl)), 1851);

        // Back-to-back saturating samples
        do_reset();
        send(16'h7000);
        send(16'hFC18);
        idle(1);
        chk("s3_vld_a", int'(PID_vld), 1);
        chk("s3_cntrl_a", int'($signed(PID_cntrl)), 3129);
        idle(1);
        chk("s3_vld_b", int'(PID_vld), 1);
        chk("s3_cntrl_b", int'($signed(PID_cntrl)), -3137);
        idle(3);
        chk("s3_count", got.size(), 2);

        // Integrator overflow hold over a long positive run
        do_reset();
        for (int k = 0; k < 300; k++) send(16'h7FFF);
        idle(4);
        chk("s4_count", got.size(), 300);
        if (got.size() == 300) begin
            neg_cnt = 0;
            foreach (got[k]) if (got[k] < 0) neg_cnt++;
            chk("s4_no_neg", neg_cnt, 0);
            chk("s4_first", got[0], 3129);
            chk("s4_second", got[1], 3137);
            chk("s4_mid", got[100], 3361);
            chk("s4_at_hold", got[255], 4599);
            chk("s4_last", got[299], 4599);
        end

        // rider_off clears integrator; pwr_up low clears D history
        do_reset();
        for (int k = 0; k < 10; k++) send(16'h0100);
        idle(3);
        chk("s5_pre_count", got.size(), 10);
        got.delete();
        rider_off = 1'b1;
        idle(1);
        rider_off = 1'b0;
        send(16'h0100);
        idle(3);
        chk("s5_rider_count", got.size(), 1);
        if (got.size() == 1) chk("s5_rider_cntrl", got[0], 1284);
        got.delete();
        pwr_up = 1'b0;
        idle(1);
        pwr_up = 1'b1;
        send(16'h0100);
        idle(3);
        chk("s5_pwr_count", got.size(), 1);
        if (got.size() == 1) chk("s5_pwr_cntrl", got[0], 1851);

        // Reset while a sample is in flight
        do_reset();
        send(16'h0100);
        rst = 1'b1;
        idle(1);
        chk("s6_rst_vld", int'(PID_vld), 0);
        chk("s6_rst_cntrl", int'($signed(PID_cntrl)), 0);
        rst = 1'b0;
        idle(5);
        chk("s6_flushed", got.size(), 0);
        chk("s6_cntrl_zero", int'($signed(PID_cntrl)), 0);
        send(16'h0100);
        idle(3);
        chk("s6_after_count", got.size(), 1);
        if (got.size() == 1) chk("s6_after_cntrl", got[0], 1851);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
